// File: rtl/rggen_bus_responder_if.sv
// rggen external bus: one request/response channel between a master and a responder.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) ();
  logic                     valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, address, write, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, address, write, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_bus_responder.sv
// Responder end of the rggen bus: small word store with programmable wait states and a HW read port.
// Optional RGGEN_BUS_RESPONDER_STROBE_ERROR_EN: in-range writes with an all-zero strobe return SLAVE_ERROR.
module rggen_bus_responder #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       BUS_WIDTH     = 32,
  parameter int                       WORDS         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
  parameter int                       WAIT_CYCLES   = 0,
  parameter logic [BUS_WIDTH-1:0]     INIT_VALUE    = '0,
  localparam int                      IDX_W         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bus_if.slave           bus_if,
  input  logic [IDX_W-1:0]     i_hw_index,
  output logic [BUS_WIDTH-1:0] o_hw_data
);
  localparam int STRB_W   = BUS_WIDTH / 8;
  localparam int LSB      = $clog2(STRB_W);
  localparam int HW_DEPTH = 2 ** IDX_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] OKAY         = 2'b00;
  localparam logic [1:0] SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] DECODE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 ready_q;
  logic [1:0]           status_q;
  logic [BUS_WIDTH-1:0] rdata_q;
  logic                 req_write_q;
  logic                 req_hit_q;
  logic [IDX_W-1:0]     req_idx_q;
  logic [BUS_WIDTH-1:0] req_wdata_q;
  logic [STRB_W-1:0]    req_strb_q;

  logic [BUS_WIDTH-1:0] mem_q [WORDS];
  logic [BUS_WIDTH-1:0] hw_tbl [HW_DEPTH];

  logic [ADDRESS_WIDTH:0]   diff;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     hit;
  logic [IDX_W-1:0]         idx;
  logic                     enter_ack;
  logic [1:0]               status_d;
  logic [BUS_WIDTH-1:0]     rdata_d;

  // The extra MSB of the difference is the borrow, i.e. address below the window
  assign diff   = {1'b0, bus_if.address} - {1'b0, BASE_ADDRESS};
  assign offset = diff[ADDRESS_WIDTH-1:0] >> LSB;
  assign hit    = !diff[ADDRESS_WIDTH] && (32'(offset) < 32'(WORDS));
  assign idx    = offset[IDX_W-1:0];

  // Index space padded to a power of two so out-of-range indices read as zero
  for (genvar g = 0; g < HW_DEPTH; g++) begin : g_hw_tbl
    if (g < WORDS) begin : g_word
      assign hw_tbl[g] = mem_q[g];
    end else begin : g_pad
      assign hw_tbl[g] = '0;
    end
  end

  assign o_hw_data = hw_tbl[i_hw_index];

  assign enter_ack = ((state_q == ST_IDLE) && bus_if.valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    status_d = OKAY;
    rdata_d  = '0;
    if (!hit) begin
      status_d = DECODE_ERROR;
    end else if (!bus_if.write) begin
      rdata_d = hw_tbl[idx];
    end
`ifdef RGGEN_BUS_RESPONDER_STROBE_ERROR_EN
    else if (bus_if.strobe == '0) begin
      status_d = SLAVE_ERROR;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      status_q    <= OKAY;
      rdata_q     <= '0;
      req_write_q <= 1'b0;
      req_hit_q   <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.valid) begin
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      ready_q <= enter_ack;
      // Request is captured on the edge entering ACK; the master keeps it stable until then
      if (enter_ack) begin
        req_write_q <= bus_if.write;
        req_hit_q   <= hit;
        req_idx_q   <= idx;
        req_wdata_q <= bus_if.write_data;
        req_strb_q  <= bus_if.strobe;
        status_q    <= status_d;
        rdata_q     <= rdata_d;
      end
    end
  end

  // Write commits on the edge leaving ACK; an all-zero strobe naturally changes nothing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= INIT_VALUE;
      end
    end else if ((state_q == ST_ACK) && req_write_q && req_hit_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (req_strb_q[b]) begin
          mem_q[req_idx_q][8*b +: 8] <= req_wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus_if.ready     = ready_q;
  assign bus_if.status    = status_q;
  assign bus_if.read_data = rdata_q;
endmodule

// File: doc/rggen_bus_responder.md
# rggen_bus_responder

Responder (slave) end of the rggen external bus. Accepts requests from an upstream bus master over `rggen_bus_if`, serves them from a small internal word array after a programmable number of wait cycles, and returns `ready`, `status` and `read_data`. Used as the endpoint behind an external-register window: as a stand-in peripheral in subsystem benches and as a real scratch/mailbox block. A hardware-side read port exposes the stored words to local logic.

## Interface
- `ADDRESS_WIDTH`, 8: bus address width in bits.
- `BUS_WIDTH`, 32: data width in bits; power of two, ≥ 8.
- `WORDS`, 4: number of BUS_WIDTH-bit words stored; ≥ 1.
- `BASE_ADDRESS`, '0: byte address of word 0; aligned to BUS_WIDTH/8.
- `WAIT_CYCLES`, 0: wait cycles inserted before `ready`; 0..15.
- `INIT_VALUE`, '0: reset value of every stored word.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `bus_if` modport `rggen_bus_if.slave`: `valid`, `address`, `write`, `write_data`, `strobe` (BUS_WIDTH/8 bits, byte enables) in; `ready`, `status` (2 bits), `read_data` out.
- `i_hw_index` input clog2(WORDS) (min 1): word index for the hardware read port.
- `o_hw_data` output BUS_WIDTH: combinational read of word `i_hw_index`; '0 if the index is ≥ WORDS.

## Operation
- Word offset = (`address` − BASE_ADDRESS) >> clog2(BUS_WIDTH/8). The request is in range iff `address` ≥ BASE_ADDRESS and offset < WORDS. Low address bits below the word boundary are ignored.
- Status codes: OKAY = 2'b00; SLAVE_ERROR = 2'b10; DECODE_ERROR = 2'b11.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on `valid`=1, load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else go to ACK.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACK.
  - ACK: `ready`=1 for exactly this one cycle, then go to IDLE unconditionally.
- The request fields (`address`, `write`, `write_data`, `strobe`) are sampled on the edge that enters ACK. The master holds them stable while `valid`=1.
- `read_data` and `status` are registered on the edge entering ACK and are valid while `ready`=1.
- Read, in range: `read_data` = stored word; `status` = OKAY.
- Write, in range: bytes with `strobe[i]`=1 are updated on the edge that leaves ACK. `read_data` = '0; `status` = OKAY.
- Out of range, read or write: no storage change; `read_data` = '0; `status` = DECODE_ERROR.
- Outside ACK: `ready`=0, and `read_data`/`status` hold their last value.
- If `valid` drops before ACK (protocol violation), the FSM still completes to ACK, the access is still performed, and `ready` is still pulsed.
- `o_hw_data` reflects a write on the cycle after the ACK cycle.

## Timing
- Reset values: `ready`=0, `status`=2'b00, `read_data`='0, FSM=IDLE, counter=0, all words=INIT_VALUE.
- Latency: `valid` first sampled high at edge N, so `ready`=1 during cycle N+WAIT_CYCLES+1.
- Minimum turnaround: the master clears `valid` on the ACK edge, so the next request can be sampled one cycle after ACK. Worst-case throughput is one access per WAIT_CYCLES+2 cycles.
- `valid` still high in the cycle after ACK (master not yet dropped) is treated as a new request.
- Reset asserted mid-access (WAIT or ACK): immediately return to IDLE with `ready`=0; no partial write; the storage reinitialises to INIT_VALUE.
- Reading the hardware port in the same cycle as a bus write returns the old value.

## Configuration
- `RGGEN_BUS_RESPONDER_STROBE_ERROR_EN`:
  - Defined: an in-range write with `strobe`=0 returns SLAVE_ERROR and leaves storage unchanged.
  - Undefined: the same write returns OKAY as a no-op.
  - Out-of-range and read behaviour is identical in both builds.

## Test plan
All scenarios use BUS_WIDTH=32, WORDS=4, BASE_ADDRESS=8'h40, INIT_VALUE=32'hDEAD_BEEF.
- Reset, WAIT_CYCLES=2: read 8'h44 → `ready` three cycles after `valid`, `read_data`=32'hDEADBEEF, `status`=00; `o_hw_data`(index 1)=32'hDEADBEEF.
- Write 8'h48 with data 32'h1234_5678 and `strobe`=4'b0101, then read 8'h48 → 32'hDE34BE78, `status`=00; `o_hw_data`(index 2) matches on the cycle after the write's ACK.
- Read 8'h50 and write 8'h3C → both give `status`=11, `read_data`=0, and all words unchanged.
- Write 8'h40 with `strobe`=0 → `status`=10 with the macro defined and 00 without; in both builds word 0 stays 32'hDEADBEEF.
- WAIT_CYCLES=0, back-to-back write then read of 8'h4C → each `ready` arrives one cycle after `valid` is sampled, and the read returns the written data.
- Assert `i_rst_n` during WAIT of a write to 8'h44 → `ready` never pulses, and a subsequent read returns 32'hDEADBEEF.
